// File: rtl/vec_mem_responder_if.sv
// Request/response bundle between vec_lsu (master) and vec_mem_responder (slave).
interface vec_mem_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      ld_req;
    logic                      st_req;
    logic [ADDR_WIDTH-1:0]     lsu2mem_addr;
    logic [DATA_WIDTH-1:0]     lsu2mem_data;
    logic [DATA_WIDTH/8-1:0]   lsu2mem_wmask;
    logic                      mem_ready;
    logic [DATA_WIDTH-1:0]     mem2lsu_data;
    logic                      mem2lsu_valid;
    logic                      mem2lsu_err;
    logic                      lsu_rsp_ready;
    logic                      st_ack;
    logic                      st_err;
    logic                      req_err;

    modport master (
        output ld_req, st_req, lsu2mem_addr, lsu2mem_data, lsu2mem_wmask, lsu_rsp_ready,
        input  mem_ready, mem2lsu_data, mem2lsu_valid, mem2lsu_err, st_ack, st_err, req_err
    );

    modport slave (
        input  ld_req, st_req, lsu2mem_addr, lsu2mem_data, lsu2mem_wmask, lsu_rsp_ready,
        output mem_ready, mem2lsu_data, mem2lsu_valid, mem2lsu_err, st_ack, st_err, req_err
    );
endinterface

// File: rtl/vec_mem_responder.sv
// Word memory answering vec_lsu loads/stores with fixed-latency, credit-limited in-order responses.
// Optional byte-granular stores are enabled by defining VEC_MEM_BYTE_WMASK_EN.
module vec_mem_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int RD_LATENCY = 2,
    parameter int RSP_DEPTH  = 4
) (
    input logic                clk,
    input logic                n_rst,
    vec_mem_responder_if.slave bus
);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W  = $clog2(RSP_DEPTH + 1);

    logic [DATA_WIDTH-1:0] memArray [DEPTH];

    logic [RD_LATENCY-1:0] pipeValid_q;
    logic [RD_LATENCY-1:0] pipeErr_q;
    logic [DATA_WIDTH-1:0] pipeData_q [RD_LATENCY];

    logic [DATA_WIDTH-1:0] fifoData_q [RSP_DEPTH];
    logic [RSP_DEPTH-1:0]  fifoErr_q;
    logic [PTR_W-1:0]      wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]      rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic readyEn_q;
    logic stAck_q, stErr_q, reqErr_q;

    logic [IDX_W-1:0]      reqIdx;
    logic [ADDR_WIDTH-1:0] upperBits;
    logic                  addrErr;
    logic [DATA_WIDTH-1:0] rdData;
    logic [31:0]           inflight;
    logic                  memReady;
    logic                  accept, doLoad, doStore;
    logic                  fifoValid, push, pop;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(RSP_DEPTH - 1)) return '0;
        return ptr + PTR_W'(1);
    endfunction

    // Credit accounting counts every load that will eventually occupy a FIFO slot.
    always_comb begin
        inflight = 32'(count_q);
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + 32'(pipeValid_q[i]);
        end
        memReady = readyEn_q && (inflight < 32'(RSP_DEPTH));
    end

    always_comb begin
        reqIdx    = bus.lsu2mem_addr[IDX_W+1:2];
        upperBits = bus.lsu2mem_addr >> (IDX_W + 2);
        addrErr   = (bus.lsu2mem_addr[1:0] != 2'b00) || (upperBits != '0);
        rdData    = addrErr ? '0 : memArray[reqIdx];
        accept    = n_rst && memReady && (bus.ld_req ^ bus.st_req);
        doLoad    = accept && bus.ld_req;
        doStore   = accept && bus.st_req;
        fifoValid = (count_q != '0);
        push      = pipeValid_q[RD_LATENCY-1];
        pop       = fifoValid && bus.lsu_rsp_ready;
    end

    always_comb begin
        wrPtr_d = push ? nextPtr(wrPtr_q) : wrPtr_q;
        rdPtr_d = pop ? nextPtr(rdPtr_q) : rdPtr_q;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            pipeValid_q <= '0;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            readyEn_q   <= 1'b0;
            stAck_q     <= 1'b0;
            stErr_q     <= 1'b0;
            reqErr_q    <= 1'b0;
        end else begin
            pipeValid_q[0] <= doLoad;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipeValid_q[i] <= pipeValid_q[i-1];
            end
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            count_q   <= count_d;
            readyEn_q <= 1'b1;
            stAck_q   <= doStore;
            stErr_q   <= doStore && addrErr;
            reqErr_q  <= bus.ld_req && bus.st_req;
        end
    end

    // Payload storage is qualified by the valid bits above, so it needs no reset.
    always_ff @(posedge clk) begin
        pipeData_q[0] <= rdData;
        pipeErr_q[0]  <= addrErr;
        for (int i = 1; i < RD_LATENCY; i++) begin
            pipeData_q[i] <= pipeData_q[i-1];
            pipeErr_q[i]  <= pipeErr_q[i-1];
        end
        if (push) begin
            fifoData_q[wrPtr_q] <= pipeData_q[RD_LATENCY-1];
            fifoErr_q[wrPtr_q]  <= pipeErr_q[RD_LATENCY-1];
        end
    end

`ifdef VEC_MEM_BYTE_WMASK_EN
    always_ff @(posedge clk) begin
        if (doStore && !addrErr) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (bus.lsu2mem_wmask[b]) begin
                    memArray[reqIdx][b*8 +: 8] <= bus.lsu2mem_data[b*8 +: 8];
                end
            end
        end
    end
`else
    logic unusedWmask;
    assign unusedWmask = ^bus.lsu2mem_wmask;

    always_ff @(posedge clk) begin
        if (doStore && !addrErr) begin
            memArray[reqIdx] <= bus.lsu2mem_data;
        end
    end
`endif

    assign bus.mem_ready     = memReady;
    assign bus.mem2lsu_valid = fifoValid;
    assign bus.mem2lsu_data  = fifoValid ? fifoData_q[rdPtr_q] : '0;
    assign bus.mem2lsu_err   = fifoValid ? fifoErr_q[rdPtr_q] : 1'b0;
    assign bus.st_ack        = stAck_q;
    assign bus.st_err        = stErr_q;
    assign bus.req_err       = reqErr_q;
endmodule

// File: tb/tb_vec_mem_responder.sv
// Directed self-checking bench for vec_mem_responder with default parameters (RD_LATENCY=2, RSP_DEPTH=4).
module tb_vec_mem_responder;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic n_rst;
    int   total = 0;
    int   bad = 0;
    int   got;
    logic acceptNow;
    logic [31:0] maskedExp;
    logic [31:0] zeroMaskExp;

    vec_mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    vec_mem_responder #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(1024), .RD_LATENCY(LAT), .RSP_DEPTH(4)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ld, input logic st, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [3:0] mask);
        bus.ld_req        = ld;
        bus.st_req        = st;
        bus.lsu2mem_addr  = addr;
        bus.lsu2mem_data  = data;
        bus.lsu2mem_wmask = mask;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic issue(input logic ld, input logic st, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] mask);
        applyStimulus(ld, st, addr, data, mask);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    // Issues one load into an idle responder and checks latency, data and error flag.
    task automatic loadAndCheck(input string tag, input logic [31:0] addr,
                                input logic [31:0] expData, input logic expErr);
        int waits = 0;
        issue(1'b1, 1'b0, addr, 32'h0, 4'h0);
        while (bus.mem2lsu_valid !== 1'b1 && waits < 10) begin
            tick();
            waits++;
        end
        checkOutput({tag, "_lat"}, 64'(waits), 64'(LAT));
        checkOutput({tag, "_data"}, 64'(bus.mem2lsu_data), 64'(expData));
        checkOutput({tag, "_err"}, 64'(bus.mem2lsu_err), 64'(expErr));
        tick();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
`ifdef VEC_MEM_BYTE_WMASK_EN
        maskedExp   = 32'h11BB33DD;
        zeroMaskExp = 32'h11BB33DD;
`else
        maskedExp   = 32'hAABBCCDD;
        zeroMaskExp = 32'hCAFEF00D;
`endif
        n_rst = 1'b0;
        bus.lsu_rsp_ready = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        tick();
        checkOutput("rst_ready", 64'(bus.mem_ready), 64'd0);
        checkOutput("rst_valid", 64'(bus.mem2lsu_valid), 64'd0);
        checkOutput("rst_data", 64'(bus.mem2lsu_data), 64'd0);
        checkOutput("rst_err", 64'(bus.mem2lsu_err), 64'd0);
        checkOutput("rst_st_ack", 64'(bus.st_ack), 64'd0);
        checkOutput("rst_st_err", 64'(bus.st_err), 64'd0);
        checkOutput("rst_req_err", 64'(bus.req_err), 64'd0);
        n_rst = 1'b1;
        tick();
        checkOutput("post_rst_ready", 64'(bus.mem_ready), 64'd1);

        $display("[TB] store then load");
        issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        checkOutput("st_ack", 64'(bus.st_ack), 64'd1);
        checkOutput("st_err", 64'(bus.st_err), 64'd0);
        loadAndCheck("st_ld", 32'h10, 32'hDEADBEEF, 1'b0);
        checkOutput("st_ack_pulse", 64'(bus.st_ack), 64'd0);
        checkOutput("st_ld_drained", 64'(bus.mem2lsu_valid), 64'd0);

        $display("[TB] back-to-back loads under backpressure");
        for (int i = 0; i < 5; i++) begin
            issue(1'b0, 1'b1, 32'(i * 4), 32'(i + 1), 4'hF);
        end
        bus.lsu_rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkOutput("bp_ready_pre", 64'(bus.mem_ready), 64'd1);
            issue(1'b1, 1'b0, 32'(i * 4), 32'h0, 4'h0);
        end
        checkOutput("bp_ready_full", 64'(bus.mem_ready), 64'd0);
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        tick();
        tick();
        tick();
        checkOutput("bp_ready_held", 64'(bus.mem_ready), 64'd0);
        checkOutput("bp_head", 64'(bus.mem2lsu_data), 64'd1);
        bus.lsu_rsp_ready = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 20 && got < 5; cyc++) begin
            acceptNow = bus.ld_req && bus.mem_ready;
            if (bus.mem2lsu_valid) begin
                checkOutput("bp_rsp", 64'(bus.mem2lsu_data), 64'(got + 1));
                got++;
            end
            tick();
            if (acceptNow) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        end
        checkOutput("bp_count", 64'(got), 64'd5);
        tick();
        checkOutput("bp_drained", 64'(bus.mem2lsu_valid), 64'd0);

        $display("[TB] error addresses");
        loadAndCheck("err_ld", 32'h13, 32'h0, 1'b1);
        issue(1'b0, 1'b1, 32'h1000, 32'h55, 4'hF);
        checkOutput("err_st_ack", 64'(bus.st_ack), 64'd1);
        checkOutput("err_st_err", 64'(bus.st_err), 64'd1);
        loadAndCheck("err_st_word0", 32'h0, 32'h1, 1'b0);

        $display("[TB] simultaneous requests");
        issue(1'b0, 1'b1, 32'h20, 32'h77, 4'hF);
        tick();
        issue(1'b1, 1'b1, 32'h20, 32'h99, 4'hF);
        checkOutput("dual_req_err", 64'(bus.req_err), 64'd1);
        checkOutput("dual_st_ack", 64'(bus.st_ack), 64'd0);
        tick();
        checkOutput("dual_req_err_pulse", 64'(bus.req_err), 64'd0);
        tick();
        tick();
        checkOutput("dual_no_rsp", 64'(bus.mem2lsu_valid), 64'd0);
        loadAndCheck("dual_mem", 32'h20, 32'h77, 1'b0);

        $display("[TB] reset mid-flight");
        issue(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        issue(1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
        n_rst = 1'b0;
        tick();
        checkOutput("midrst_valid", 64'(bus.mem2lsu_valid), 64'd0);
        checkOutput("midrst_ready", 64'(bus.mem_ready), 64'd0);
        n_rst = 1'b1;
        tick();
        checkOutput("midrst_ready_after", 64'(bus.mem_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("midrst_no_rsp", 64'(bus.mem2lsu_valid), 64'd0);
            tick();
        end

        $display("[TB] byte mask");
        issue(1'b0, 1'b1, 32'h40, 32'h11223344, 4'hF);
        issue(1'b0, 1'b1, 32'h40, 32'hAABBCCDD, 4'b0101);
        checkOutput("mask_st_ack", 64'(bus.st_ack), 64'd1);
        checkOutput("mask_st_err", 64'(bus.st_err), 64'd0);
        loadAndCheck("mask_ld", 32'h40, maskedExp, 1'b0);
        issue(1'b0, 1'b1, 32'h40, 32'hCAFEF00D, 4'h0);
        checkOutput("zmask_st_ack", 64'(bus.st_ack), 64'd1);
        loadAndCheck("zmask_ld", 32'h40, zeroMaskExp, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
